// File: rtl/pea_kxk_acc_if.sv
// Control, load and result handshake bundle for the KxK accumulating PE array.
// master drives jobs and beats; slave is the array.
interface pea_kxk_acc_if #(
    parameter int K      = 3,
    parameter int COL    = 8,
    parameter int DW     = 8,
    parameter int PSUM_W = 32,
    parameter int ICW    = 8
) ();
    logic                      start;
    logic                      cfg_stride;
    logic [ICW-1:0]            cfg_ic_num;
    logic                      wgt_valid;
    logic                      wgt_ready;
    logic [K*DW-1:0]           wgt_data;
    logic                      ifm_valid;
    logic                      ifm_ready;
    logic [(K+COL-1)*DW-1:0]   ifm_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [COL*PSUM_W-1:0]     out_data;
    logic [COL-1:0]            out_mask;
    logic                      busy;

    modport master (
        output start, cfg_stride, cfg_ic_num,
        output wgt_valid, wgt_data, ifm_valid, ifm_data, out_ready,
        input  wgt_ready, ifm_ready, out_valid, out_data, out_mask, busy
    );

    modport slave (
        input  start, cfg_stride, cfg_ic_num,
        input  wgt_valid, wgt_data, ifm_valid, ifm_data, out_ready,
        output wgt_ready, ifm_ready, out_valid, out_data, out_mask, busy
    );
endinterface

// File: rtl/pea_kxk_acc.sv
// KxK convolution PE array: loads a kernel and a K-row window per channel,
// accumulates COL sliding-window dot products over channels, emits masked sums.
module pea_kxk_acc #(
    parameter int K      = 3,
    parameter int COL    = 8,
    parameter int DW     = 8,
    parameter int PSUM_W = 32,
    parameter int ICW    = 8
) (
    input logic          clk,
    input logic          rst,
    pea_kxk_acc_if.slave io
);
    localparam int XN = K + COL - 1;
    localparam int BW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_I, S_ACC, S_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [ICW-1:0]           ch_q, ch_d;
    logic [ICW-1:0]           ic_num_q, ic_num_d;
    logic                     stride_q, stride_d;
    logic signed [DW-1:0]     w_q [K][K];
    logic signed [DW-1:0]     w_d [K][K];
    logic signed [DW-1:0]     x_q [K][XN];
    logic signed [DW-1:0]     x_d [K][XN];
    logic [PSUM_W-1:0]        acc_q [COL];
    logic [PSUM_W-1:0]        acc_d [COL];
    logic                     wgt_ready_q, wgt_ready_d;
    logic                     ifm_ready_q, ifm_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;

    logic signed [2*DW-1:0]   prod;
    logic signed [PSUM_W-1:0] psum [COL];

    // Full-precision products, sign-extended before the column reduction.
    always_comb begin
        prod = '0;
        for (int c = 0; c < COL; c++) begin
            psum[c] = '0;
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) begin
                    prod = (2*DW)'(w_q[r][k]) * (2*DW)'(x_q[r][c+k]);
                    psum[c] = psum[c] + PSUM_W'(prod);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        ch_d     = ch_q;
        ic_num_d = ic_num_q;
        stride_d = stride_q;
        w_d      = w_q;
        x_d      = x_q;
        acc_d    = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    stride_d = io.cfg_stride;
                    ic_num_d = io.cfg_ic_num;
                    ch_d     = '0;
                    beat_d   = '0;
                    state_d  = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (io.wgt_valid) begin
                    for (int k = 0; k < K; k++)
                        w_d[beat_q][k] = io.wgt_data[k*DW +: DW];
                    if (beat_q == BW'(K-1)) begin
                        beat_d  = '0;
                        state_d = S_LOAD_I;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_LOAD_I: begin
                if (io.ifm_valid) begin
                    for (int j = 0; j < XN; j++)
                        x_d[beat_q][j] = io.ifm_data[j*DW +: DW];
                    if (beat_q == BW'(K-1)) begin
                        beat_d  = '0;
                        state_d = S_ACC;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_ACC: begin
                for (int c = 0; c < COL; c++)
                    acc_d[c] = (ch_q == '0) ? psum[c] : acc_q[c] + psum[c];
                if (ch_q == ic_num_q) begin
                    state_d = S_OUT;
                end else begin
                    ch_d    = ch_q + ICW'(1);
                    state_d = S_LOAD_W;
                end
            end
            S_OUT: begin
                if (io.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake outputs are registered from the next state.
        wgt_ready_d = (state_d == S_LOAD_W);
        ifm_ready_d = (state_d == S_LOAD_I);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            ch_q        <= '0;
            ic_num_q    <= '0;
            stride_q    <= 1'b0;
            w_q         <= '{default: '0};
            x_q         <= '{default: '0};
            acc_q       <= '{default: '0};
            wgt_ready_q <= 1'b0;
            ifm_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            ch_q        <= ch_d;
            ic_num_q    <= ic_num_d;
            stride_q    <= stride_d;
            w_q         <= w_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            wgt_ready_q <= wgt_ready_d;
            ifm_ready_q <= ifm_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign io.wgt_ready = wgt_ready_q;
    assign io.ifm_ready = ifm_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.busy      = busy_q;

    // Stride 2 keeps only even columns; masked columns read as zero.
    for (genvar c = 0; c < COL; c++) begin : g_out
        logic col_en;
        assign col_en = out_valid_q & (~stride_q | (c % 2 == 0));
        assign io.out_mask[c] = col_en;
        assign io.out_data[c*PSUM_W +: PSUM_W] = col_en ? acc_q[c] : '0;
    end
endmodule

// File: tb/tb_pea_kxk_acc.sv
// Scoreboard bench for pea_kxk_acc: random and directed jobs against a
// plain-arithmetic convolution model, with a 16-bit accumulator twin.
module tb_pea_kxk_acc;
    localparam int K   = 3;
    localparam int COL = 8;
    localparam int DW  = 8;
    localparam int PW  = 32;
    localparam int ICW = 8;
    localparam int XN  = K + COL - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pea_kxk_acc_if #(.K(K), .COL(COL), .DW(DW), .PSUM_W(PW), .ICW(ICW)) bus ();
    pea_kxk_acc_if #(.K(K), .COL(COL), .DW(DW), .PSUM_W(16), .ICW(ICW)) bus16 ();

    pea_kxk_acc #(.K(K), .COL(COL), .DW(DW), .PSUM_W(PW), .ICW(ICW)) dut (
        .clk(clk), .rst(rst), .io(bus)
    );
    pea_kxk_acc #(.K(K), .COL(COL), .DW(DW), .PSUM_W(16), .ICW(ICW)) dut16 (
        .clk(clk), .rst(rst), .io(bus16)
    );

    logic out_ready_r = 1'b0;
    assign bus.out_ready    = out_ready_r;
    assign bus16.start      = bus.start;
    assign bus16.cfg_stride = bus.cfg_stride;
    assign bus16.cfg_ic_num = bus.cfg_ic_num;
    assign bus16.wgt_valid  = bus.wgt_valid;
    assign bus16.wgt_data   = bus.wgt_data;
    assign bus16.ifm_valid  = bus.ifm_valid;
    assign bus16.ifm_data   = bus.ifm_data;
    assign bus16.out_ready  = bus.out_ready;

    typedef struct {
        logic [COL*PW-1:0] data;
        logic [COL-1:0]    mask;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   hold_ready = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready_r = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    function automatic void check(string nm, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    task automatic timeout(string nm);
        total++;
        bad++;
        $display("FAIL %s timeout", nm);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench aborted");
    endtask

    // Monitor: pops the oldest expected result on each output handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 256'(bus.out_valid), 256'(0));
            end else begin
                exp_t e;
                logic [COL*16-1:0] d16;
                e = sb.pop_front();
                for (int c = 0; c < COL; c++)
                    d16[c*16 +: 16] = e.data[c*PW +: 16];
                check("out_data", 256'(bus.out_data), 256'(e.data));
                check("out_mask", 256'(bus.out_mask), 256'(e.mask));
                check("out_data16", 256'(bus16.out_data), 256'(d16));
                check("out_valid16", 256'(bus16.out_valid), 256'(1));
            end
        end
    end

    function automatic int gen_w(int mode);
        case (mode)
            0: return 1;
            1: return 2;
            2: return int'($urandom_range(0, 255)) - 128;
            3: return 1;
            default: return -128;
        endcase
    endfunction

    function automatic int gen_x(int mode, int j);
        case (mode)
            0: return 1;
            1: return 3;
            2: return int'($urandom_range(0, 255)) - 128;
            3: return j;
            default: return -128;
        endcase
    endfunction

    task automatic send_w(input logic [K*DW-1:0] d, input int gap);
        int n;
        repeat (gap) begin
            bus.ifm_valid = 1'b1;
            bus.ifm_data  = (XN*DW)'({$urandom(), $urandom(), $urandom()});
            @(posedge clk); #1;
        end
        bus.ifm_valid = 1'b0;
        bus.wgt_valid = 1'b1;
        bus.wgt_data  = d;
        n = 0;
        while (!bus.wgt_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) timeout("wgt_ready");
        end
        @(posedge clk); #1;
        bus.wgt_valid = 1'b0;
    endtask

    task automatic send_x(input logic [XN*DW-1:0] d, input int gap);
        int n;
        repeat (gap) begin
            bus.wgt_valid = 1'b1;
            bus.wgt_data  = (K*DW)'($urandom());
            @(posedge clk); #1;
        end
        bus.wgt_valid = 1'b0;
        bus.ifm_valid = 1'b1;
        bus.ifm_data  = d;
        n = 0;
        while (!bus.ifm_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) timeout("ifm_ready");
        end
        @(posedge clk); #1;
        bus.ifm_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) timeout("idle");
        end
    endtask

    task automatic kick(input int ic, input bit stride);
        wait_idle();
        bus.cfg_stride = stride;
        bus.cfg_ic_num = ic[ICW-1:0];
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    // gmode 0: back-to-back; 1: one idle cycle per weight beat; 2: random gaps.
    task automatic run_job(input int ic, input bit stride, input int mode,
                           input int gmode, input bit lat);
        int w [K][K];
        int x [K][XN];
        longint s [COL];
        logic [K*DW-1:0] wd;
        logic [XN*DW-1:0] xd;
        exp_t e;
        int t0, n, gw, gx;
        kick(ic, stride);
        t0 = cyc;
        for (int c = 0; c < COL; c++) s[c] = 0;
        for (int ch = 0; ch <= ic; ch++) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) w[r][k] = gen_w(mode);
                for (int j = 0; j < XN; j++) x[r][j] = gen_x(mode, j);
            end
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) wd[k*DW +: DW] = w[r][k][DW-1:0];
                gw = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
                send_w(wd, gw);
            end
            for (int r = 0; r < K; r++) begin
                for (int j = 0; j < XN; j++) xd[j*DW +: DW] = x[r][j][DW-1:0];
                gx = (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
                send_x(xd, gx);
            end
            for (int c = 0; c < COL; c++)
                for (int r = 0; r < K; r++)
                    for (int k = 0; k < K; k++)
                        s[c] += longint'(w[r][k] * x[r][c+k]);
        end
        for (int c = 0; c < COL; c++) begin
            e.mask[c] = !stride || (c % 2 == 0);
            e.data[c*PW +: PW] = e.mask[c] ? s[c][PW-1:0] : '0;
        end
        sb.push_back(e);
        if (lat) begin
            n = 0;
            while (!bus.out_valid) begin
                @(posedge clk); #1;
                n++;
                if (n > 50) timeout("out_valid");
            end
            check("latency", 256'(cyc - t0 + 1), 256'(1 + (ic + 1) * (2*K + 1)));
        end
    endtask

    initial begin
        logic [COL*PW-1:0] snap;
        int n;
        bus.start = 0; bus.cfg_stride = 0; bus.cfg_ic_num = '0;
        bus.wgt_valid = 0; bus.wgt_data = '0;
        bus.ifm_valid = 0; bus.ifm_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(bus.out_valid), 256'(0));
        check("rst_out_data", 256'(bus.out_data), 256'(0));
        check("rst_out_mask", 256'(bus.out_mask), 256'(0));
        check("rst_wgt_ready", 256'(bus.wgt_ready), 256'(0));
        check("rst_ifm_ready", 256'(bus.ifm_ready), 256'(0));
        check("rst_busy", 256'(bus.busy), 256'(0));
        rst = 1'b0;
        hold_ready = 1'b0;

        run_job(0, 0, 0, 0, 1);
        run_job(0, 1, 0, 0, 1);
        run_job(3, 0, 1, 1, 0);
        run_job(0, 0, 4, 0, 1);
        run_job(255, 0, 4, 0, 0);
        run_job(0, 0, 3, 0, 1);
        run_job(1, 1, 3, 2, 0);
        for (int i = 0; i < 8; i++)
            run_job(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 2,
                    (i % 2) ? 2 : 0, (i % 2) == 0);

        // Backpressure in OUT with start held high throughout.
        wait_idle();
        hold_ready = 1'b1;
        run_job(0, 0, 0, 0, 1);
        snap = bus.out_data;
        repeat (10) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 256'(bus.out_valid), 256'(1));
            check("hold_data", 256'(bus.out_data), 256'(snap));
            check("hold_rdy", 256'({bus.wgt_ready, bus.ifm_ready}), 256'(0));
        end
        hold_ready = 1'b0;
        n = 0;
        while (bus.out_valid) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) timeout("release");
        end
        bus.start = 1'b0;
        check("start_in_out_ignored", 256'(bus.busy), 256'(0));
        @(posedge clk); #1;
        check("still_idle", 256'(bus.busy), 256'(0));

        // Abort during LOAD_I.
        kick(0, 0);
        for (int r = 0; r < K; r++) send_w((K*DW)'($urandom()), 0);
        send_x((XN*DW)'({$urandom(), $urandom(), $urandom()}), 0);
        check("in_load_i", 256'(bus.ifm_ready), 256'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 256'(bus.busy), 256'(0));
        check("abort_valid", 256'(bus.out_valid), 256'(0));
        check("abort_rdy", 256'({bus.wgt_ready, bus.ifm_ready}), 256'(0));
        check("abort_mask", 256'(bus.out_mask), 256'(0));
        run_job(0, 0, 0, 0, 1);

        n = 0;
        while (sb.size() > 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
